// File: rtl/idu_alu_decode_pkg.sv
// rtl/idu_alu_decode_pkg.sv - shared opcodes, ALU op codes and immediate formats
package idu_alu_decode_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Shared with the ALU; branch codes are {1'b1, funct3}.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SR   = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_BEQ  = 4'b1000,
    ALU_BNE  = 4'b1001,
    ALU_BLT  = 4'b1100,
    ALU_BGE  = 4'b1101,
    ALU_BLTU = 4'b1110,
    ALU_BGEU = 4'b1111
  } alu_t_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

endpackage

// File: rtl/idu_alu_decode_imm_gen.sv
// rtl/idu_alu_decode_imm_gen.sv - RV32I immediate extraction, sign-extended to XLEN
module idu_alu_decode_imm_gen
  import idu_alu_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     inst,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] raw;

  always_comb begin
    raw = '0;
    case (fmt)
      IMM_I:   raw = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   raw = {inst[31:12], 12'b0};
      IMM_J:   raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: raw = '0;
    endcase
  end

  // Signed cast so the size cast replicates inst[31] when XLEN > 32.
  assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/idu_alu_decode.sv
// rtl/idu_alu_decode.sv - RV32I decode into the ALU operand/control bundle,
// registered in a single valid/ready output slot with flush.
module idu_alu_decode
  import idu_alu_decode_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC_OUT = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  output logic [4:0]      o_rs1_addr,
  output logic [4:0]      o_rs2_addr,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_a,
  output logic [XLEN-1:0] o_b,
  output logic            o_sub,
  output logic            o_sign,
  output logic [3:0]      o_alu_t,
  output logic            o_alu_sra,
  output logic [XLEN-1:0] o_imm,
  output logic [XLEN-1:0] o_pc,
  output logic [4:0]      o_rd,
  output logic            o_wen,
  output logic            o_is_branch,
  output logic            o_is_jal,
  output logic            o_is_jalr,
  output logic            o_illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  assign opcode     = i_inst[6:0];
  assign rd         = i_inst[11:7];
  assign funct3     = i_inst[14:12];
  assign funct7     = i_inst[31:25];
  assign o_rs1_addr = i_inst[19:15];
  assign o_rs2_addr = i_inst[24:20];

  imm_fmt_e        fmt;
  logic [XLEN-1:0] imm_val;

  // Format depends on opcode alone, keeping imm_gen outside the decode block.
  always_comb begin
    fmt = IMM_I;
    case (opcode)
      OPC_LUI, OPC_AUIPC: fmt = IMM_U;
      OPC_JAL:            fmt = IMM_J;
      OPC_BRANCH:         fmt = IMM_B;
      default:            fmt = IMM_I;
    endcase
  end

  idu_alu_decode_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst (i_inst[31:7]),
    .fmt  (fmt),
    .imm  (imm_val)
  );

  logic [XLEN-1:0] d_a, d_b, d_imm;
  logic [3:0]      d_alu_t;
  logic            d_sub, d_sign, d_sra, d_writes, d_use_imm;
  logic            d_br, d_jal, d_jalr, d_ill;
  logic            is_shift;

  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    d_a       = '0;
    d_b       = '0;
    d_alu_t   = ALU_ADD;
    d_sub     = 1'b0;
    d_sign    = 1'b0;
    d_sra     = 1'b0;
    d_writes  = 1'b0;
    d_use_imm = 1'b0;
    d_br      = 1'b0;
    d_jal     = 1'b0;
    d_jalr    = 1'b0;
    d_ill     = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == 7'b0000000 ||
            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          d_a      = i_rs1_data;
          d_b      = i_rs2_data;
          d_alu_t  = {1'b0, funct3};
          d_sub    = (funct3 == 3'b000) ? funct7[5] : (funct3[2:1] == 2'b01);
          d_sign   = (funct3 == 3'b010);
          d_sra    = (funct3 == 3'b101) && funct7[5];
          d_writes = 1'b1;
        end else begin
          d_ill = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        if ((funct3 == 3'b001 && funct7 != 7'b0000000) ||
            (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)) begin
          d_ill = 1'b1;
        end else begin
          d_a       = i_rs1_data;
          d_b       = is_shift ? XLEN'(i_inst[24:20]) : imm_val;
          d_alu_t   = {1'b0, funct3};
          d_sub     = (funct3[2:1] == 2'b01);
          d_sign    = (funct3 == 3'b010);
          d_sra     = (funct3 == 3'b101) && i_inst[30];
          d_writes  = 1'b1;
          d_use_imm = 1'b1;
        end
      end
      OPC_LUI: begin
        d_b       = imm_val;
        d_writes  = 1'b1;
        d_use_imm = 1'b1;
      end
      OPC_AUIPC: begin
        d_a       = i_pc;
        d_b       = imm_val;
        d_writes  = 1'b1;
        d_use_imm = 1'b1;
      end
      OPC_JAL: begin
        d_a       = i_pc;
        d_b       = XLEN'(4);
        d_writes  = 1'b1;
        d_use_imm = 1'b1;
        d_jal     = 1'b1;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          d_a       = i_pc;
          d_b       = XLEN'(4);
          d_writes  = 1'b1;
          d_use_imm = 1'b1;
          d_jalr    = 1'b1;
        end else begin
          d_ill = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if (funct3[2:1] == 2'b01) begin
          d_ill = 1'b1;
        end else begin
          d_a       = i_rs1_data;
          d_b       = i_rs2_data;
          d_alu_t   = {1'b1, funct3};
          d_sub     = 1'b1;
          d_sign    = (funct3[2:1] == 2'b10);
          d_use_imm = 1'b1;
          d_br      = 1'b1;
        end
      end
      default: d_ill = 1'b1;
    endcase
  end

  assign d_imm   = d_use_imm ? imm_val : '0;
  assign o_ready = ~i_flush & (~o_valid | i_ready);

  logic capture;
  assign capture = i_valid & o_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      o_valid     <= 1'b0;
      o_a         <= '0;
      o_b         <= '0;
      o_sub       <= 1'b0;
      o_sign      <= 1'b0;
      o_alu_t     <= ALU_ADD;
      o_alu_sra   <= 1'b0;
      o_imm       <= '0;
      o_pc        <= RESET_PC_OUT;
      o_rd        <= '0;
      o_wen       <= 1'b0;
      o_is_branch <= 1'b0;
      o_is_jal    <= 1'b0;
      o_is_jalr   <= 1'b0;
      o_illegal   <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (capture) begin
      o_valid     <= 1'b1;
      o_a         <= d_a;
      o_b         <= d_b;
      o_sub       <= d_sub;
      o_sign      <= d_sign;
      o_alu_t     <= d_alu_t;
      o_alu_sra   <= d_sra;
      o_imm       <= d_imm;
      o_pc        <= i_pc;
      o_rd        <= rd;
      o_wen       <= d_writes && (rd != 5'd0);
      o_is_branch <= d_br;
      o_is_jal    <= d_jal;
      o_is_jalr   <= d_jalr;
      o_illegal   <= d_ill;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_idu_alu_decode.sv
// tb/tb_idu_alu_decode.sv - table-driven bench for idu_alu_decode
module tb_idu_alu_decode;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clock = 1'b0;
  logic        reset, i_flush, i_valid, i_ready;
  logic        o_ready, o_valid;
  logic [31:0] i_inst, i_pc, i_rs1_data, i_rs2_data;
  logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd;
  logic [31:0] o_a, o_b, o_imm, o_pc;
  logic [3:0]  o_alu_t;
  logic        o_sub, o_sign, o_alu_sra, o_wen;
  logic        o_is_branch, o_is_jal, o_is_jalr, o_illegal;

  always #5 clock = ~clock;

  idu_alu_decode #(.XLEN(32), .RESET_PC_OUT(RST_PC)) dut (
    .clock(clock), .reset(reset), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_inst(i_inst), .i_pc(i_pc), .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_a(o_a), .o_b(o_b), .o_sub(o_sub), .o_sign(o_sign), .o_alu_t(o_alu_t),
    .o_alu_sra(o_alu_sra), .o_imm(o_imm), .o_pc(o_pc), .o_rd(o_rd), .o_wen(o_wen),
    .o_is_branch(o_is_branch), .o_is_jal(o_is_jal), .o_is_jalr(o_is_jalr), .o_illegal(o_illegal)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] a, b, imm;
    logic [3:0]  alu_t;
    logic [4:0]  rd;
    logic        sub, sign, sra, wen, br, jal, jalr, ill;
  } out_t;

  typedef struct {
    string       name;
    logic [31:0] inst, pc, rs1, rs2;
    out_t        exp;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic out_t mk(logic [31:0] a, b, imm, logic [3:0] alu_t, logic [4:0] rd,
                              logic sub, sign, sra, wen, br, jal, jalr, ill);
    out_t o;
    o = '{1'b1, a, b, imm, alu_t, rd, sub, sign, sra, wen, br, jal, jalr, ill};
    return o;
  endfunction

  function automatic out_t act();
    out_t o;
    o = '{o_valid, o_a, o_b, o_imm, o_alu_t, o_rd, o_sub, o_sign, o_alu_sra, o_wen,
          o_is_branch, o_is_jal, o_is_jalr, o_illegal};
    return o;
  endfunction

  task automatic add(string name, logic [31:0] inst, pc, rs1, rs2, out_t exp);
    vec_t v;
    v.name = name; v.inst = inst; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.exp = exp;
    vq.push_back(v);
  endtask

  task automatic chk_out(string name, out_t exp);
    out_t got;
    got = act();
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic chk_val(string name, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic drive(vec_t v);
    i_inst = v.inst; i_pc = v.pc; i_rs1_data = v.rs1; i_rs2_data = v.rs2;
  endtask

  initial begin
    //  name          inst          pc          rs1           rs2
    //    a             b             imm           alu   rd  sub sg sra wen br jal jalr ill
    add("addi",  32'hFFB10093, 32'h100, 32'd10, 32'h55,
        mk(32'd10, 32'hFFFFFFFB, 32'hFFFFFFFB, 4'b0000, 5'd1, 0,0,0,1, 0,0,0,0));
    add("sub",   32'h402081B3, 32'h104, 32'd7, 32'd3,
        mk(32'd7, 32'd3, 32'h0, 4'b0000, 5'd3, 1,0,0,1, 0,0,0,0));
    add("srai",  32'h40335293, 32'h108, 32'h80000000, 32'h77,
        mk(32'h80000000, 32'd3, 32'h403, 4'b0101, 5'd5, 0,0,1,1, 0,0,0,0));
    add("bltu",  32'h0020E463, 32'h10C, 32'd5, 32'd9,
        mk(32'd5, 32'd9, 32'd8, 4'b1110, 5'd8, 1,0,0,0, 1,0,0,0));
    add("addi_x0", 32'h00100013, 32'h110, 32'd0, 32'd0,
        mk(32'd0, 32'd1, 32'd1, 4'b0000, 5'd0, 0,0,0,0, 0,0,0,0));
    add("zero_ill", 32'h00000000, 32'h114, 32'h11, 32'h22,
        mk(32'd0, 32'd0, 32'd0, 4'b0000, 5'd0, 0,0,0,0, 0,0,0,1));
    add("lui",   32'h123453B7, 32'h118, 32'hDEAD, 32'hBEEF,
        mk(32'd0, 32'h12345000, 32'h12345000, 4'b0000, 5'd7, 0,0,0,1, 0,0,0,0));
    add("auipc", 32'hFFFFF217, 32'h2000, 32'h1, 32'h2,
        mk(32'h2000, 32'hFFFFF000, 32'hFFFFF000, 4'b0000, 5'd4, 0,0,0,1, 0,0,0,0));
    add("jal",   32'h010000EF, 32'h300, 32'h1, 32'h2,
        mk(32'h300, 32'd4, 32'd16, 4'b0000, 5'd1, 0,0,0,1, 0,1,0,0));
    add("jalr_x0", 32'hFFC08067, 32'h400, 32'h1234, 32'h2,
        mk(32'h400, 32'd4, 32'hFFFFFFFC, 4'b0000, 5'd0, 0,0,0,0, 0,0,1,0));
    add("slt",   32'h0041A133, 32'h404, 32'd1, 32'd2,
        mk(32'd1, 32'd2, 32'd0, 4'b0010, 5'd2, 1,1,0,1, 0,0,0,0));
    add("bge",   32'hFE20DEE3, 32'h408, 32'hFFFFFFF0, 32'd3,
        mk(32'hFFFFFFF0, 32'd3, 32'hFFFFFFFC, 4'b1101, 5'd29, 1,1,0,0, 1,0,0,0));
    add("br_f3_010", 32'h0020A463, 32'h40C, 32'h11, 32'h22,
        mk(32'd0, 32'd0, 32'd0, 4'b0000, 5'd8, 0,0,0,0, 0,0,0,1));
    add("sra",   32'h407352B3, 32'h410, 32'hF0, 32'd4,
        mk(32'hF0, 32'd4, 32'd0, 4'b0101, 5'd5, 0,0,1,1, 0,0,0,0));

    reset = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_inst = '0; i_pc = '0; i_rs1_data = '0; i_rs2_data = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk_val("reset_valid", {31'b0, o_valid}, 32'd0);
    chk_val("reset_pc", o_pc, RST_PC);
    chk_val("reset_alu_t", {28'b0, o_alu_t}, 32'd0);
    chk_val("reset_a_b", o_a | o_b, 32'd0);

    // Back-to-back issue with i_ready high: each bundle one cycle after its input.
    i_valid = 1'b1;
    foreach (vq[i]) begin
      logic [31:0] ins;
      @(negedge clock);
      drive(vq[i]);
      #1;
      ins = vq[i].inst;
      chk_val({vq[i].name, "_rsaddr"}, {22'b0, o_rs1_addr, o_rs2_addr},
              {22'b0, ins[19:15], ins[24:20]});
      @(posedge clock);
      #1;
      chk_out(vq[i].name, vq[i].exp);
      chk_val({vq[i].name, "_pc"}, o_pc, vq[i].pc);
    end

    // Backpressure: hold addi for 3 cycles while lui waits, then take lui with no bubble.
    @(negedge clock);
    drive(vq[0]); i_valid = 1'b1; i_ready = 1'b1;
    @(posedge clock); #1;
    chk_out("bp_load", vq[0].exp);
    @(negedge clock);
    drive(vq[6]); i_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      chk_val("bp_ready_low", {31'b0, o_ready}, 32'd0);
      chk_out("bp_hold", vq[0].exp);
    end
    @(negedge clock);
    i_ready = 1'b1;
    #1;
    chk_val("bp_ready_high", {31'b0, o_ready}, 32'd1);
    @(posedge clock); #1;
    chk_out("bp_next", vq[6].exp);
    @(negedge clock);
    i_valid = 1'b0;
    @(posedge clock); #1;
    chk_val("bp_drain", {31'b0, o_valid}, 32'd0);

    // Flush beats a simultaneous valid input.
    @(negedge clock);
    drive(vq[0]); i_valid = 1'b1;
    @(posedge clock); #1;
    chk_out("fl_load", vq[0].exp);
    @(negedge clock);
    drive(vq[6]); i_flush = 1'b1;
    #1;
    chk_val("fl_ready", {31'b0, o_ready}, 32'd0);
    @(posedge clock); #1;
    chk_val("fl_valid", {31'b0, o_valid}, 32'd0);
    chk_val("fl_no_capture", o_b, vq[0].exp.b);
    @(negedge clock);
    i_flush = 1'b0; i_valid = 1'b0;
    @(posedge clock); #1;
    chk_val("fl_stay_empty", {31'b0, o_valid}, 32'd0);

    // Asynchronous reset between edges.
    @(negedge clock);
    drive(vq[7]); i_valid = 1'b1;
    @(posedge clock); #1;
    chk_out("ar_load", vq[7].exp);
    @(negedge clock);
    i_valid = 1'b0; i_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_val("ar_valid", {31'b0, o_valid}, 32'd0);
    chk_val("ar_pc", o_pc, RST_PC);
    chk_val("ar_a", o_a, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/idu_alu_decode.md
Name: idu_alu_decode

Overview:
- Decode stage that produces the operand and control bundle consumed by the core ALU: a, b, sub, sign, alu_t, alu_sra.
- Takes a fetched RV32I instruction and PC from the IFU via a valid/ready handshake.
- Reads the register file through combinational read ports and registers the decoded bundle into a single output pipeline slot toward the EXU.
- Supports backpressure and flush.

Parameters:
- XLEN, 32, datapath width
- RESET_PC_OUT, 32'h0, reset value of registered o_pc

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- i_flush  in  1  kill the held bundle; EXU redirect
- i_valid  in  1  IFU bundle valid
- o_ready  out  1  decode can accept
- i_inst  in  32  instruction word
- i_pc  in  XLEN  instruction PC
- o_rs1_addr  out  5  RF read addr = i_inst[19:15], combinational
- o_rs2_addr  out  5  RF read addr = i_inst[24:20], combinational
- i_rs1_data  in  XLEN  RF read data, same cycle
- i_rs2_data  in  XLEN  RF read data, same cycle
- o_valid  out  1  bundle valid to EXU
- i_ready  in  1  EXU accepts
- o_a  out  XLEN  ALU operand a
- o_b  out  XLEN  ALU operand b, un-inverted; the ALU inverts it when sub is set
- o_sub  out  1  ALU subtract/compare
- o_sign  out  1  signed compare
- o_alu_t  out  4  ALU op code
- o_alu_sra  out  1  arithmetic right shift
- o_imm  out  XLEN  sign-extended immediate, for branch/jump targets
- o_pc  out  XLEN  registered PC
- o_rd  out  5  destination register
- o_wen  out  1  RF write enable; forced 0 when rd = 0
- o_is_branch / o_is_jal / o_is_jalr  out  1 each  control-flow class
- o_illegal  out  1  unsupported encoding

Behaviour:
- **ALU op codes:**
  - ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SR 0101, OR 0110, AND 0111.
  - Branches use alu_t = {1'b1, funct3}: BEQ 1000, BNE 1001, BLT 1100, BGE 1101, BLTU 1110, BGEU 1111.
- **Handshake:**
  - o_ready = ~o_valid | i_ready.
  - Transfer in when i_valid & o_ready: capture the decoded bundle, o_valid <= 1.
  - When i_ready & o_valid with no new input: o_valid <= 0.
  - While o_valid & ~i_ready, every output register holds its value.
- **Latency:** 1 cycle from accepted input to o_valid. Full throughput at 1 instruction/cycle when i_ready is held high.
- **Flush:** i_flush forces o_valid <= 0 the next edge and blocks capture that cycle. o_ready = 0 while i_flush is high. Flush has priority over all other events.
- **Reset:** asynchronous, takes effect immediately, including mid-transfer. On reset:
  - o_valid = 0
  - all bundle registers = 0
  - o_pc = RESET_PC_OUT
  - o_alu_t = ADD
- **OP (0110011):**
  - a = rs1, b = rs2, alu_t = {0, funct3}.
  - sub = funct7[5] for funct3 = 000, and 1 for SLT/SLTU.
  - sign = 1 only for SLT.
  - sra = funct7[5] for funct3 = 101.
- **OP-IMM (0010011):**
  - b = I-immediate; for shifts, b = {27'b0, shamt}.
  - sub = 1 for SLTI/SLTIU; sign = 1 for SLTI; sra = inst[30] for funct3 101.
  - Never set sub from funct7 for ADDI.
- **LUI:** a = 0, b = U-imm, ADD.
- **AUIPC:** a = pc, b = U-imm, ADD.
- **JAL / JALR:** a = pc, b = 4, ADD, wen = (rd != 0), o_imm = J-imm / I-imm.
- **BRANCH (1100011):**
  - a = rs1, b = rs2, sub = 1, sign = 1 for BLT/BGE.
  - wen = 0, o_imm = B-imm.
  - funct3 010/011 are illegal.
- **Illegal:** any other opcode or reserved funct field → o_illegal = 1, wen = 0, ADD with a = b = 0. The bundle is still passed through the handshake.
- **Immediates:** all are sign-extended to XLEN from inst[31].

Decomposition:
- **Shared package:** opcode constants, the 4-bit alu_t codes above (shared with the ALU), and the immediate-format enum {I, S, B, U, J}.
- **Sub-module:** combinational imm_gen (inst, format → XLEN immediate).
- **Remaining logic:** decode and the output register slot live in the top module.

Test Plan:
- ADDI x1,x2,-5 (0xFFB10093), rs1_data = 10 → next cycle o_valid = 1, o_a = 10, o_b = 0xFFFFFFFB, alu_t = 0000, sub = 0, rd = 1, wen = 1.
- SUB x3,x1,x2 (0x402081B3) → sub = 1, alu_t = 0000, sign = 0; SRAI x5,x6,3 (0x40335293) → alu_t = 0101, sra = 1, o_b = 3.
- BLTU x1,x2,+8 (0x0020E463) → alu_t = 1110, sub = 1, sign = 0, wen = 0, is_branch = 1, o_imm = 8; ADDI with rd = 0 → wen = 0.
- Backpressure: o_valid = 1, i_ready = 0 for 3 cycles with i_valid = 1 → o_ready = 0 and outputs stable. Then i_ready = 1 → new bundle loaded on the same edge, no bubble, no duplicate.
- i_flush with o_valid = 1 and i_valid = 1 → o_valid = 0 next cycle and the input is not captured. Async reset asserted mid-cycle → o_valid drops before the next edge.
- inst 0x00000000 → o_illegal = 1, wen = 0; LUI x7,0x12345 (0x123453B7) → o_a = 0, o_b = 0x12345000.
